// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundle of the seg7_scan_mux control/data signals.
//   master : drives ena, digits_in, dp_in, load; observes display outputs.
//   slave  : the scan multiplexer itself.
// Signals:
//   ena        scan enable (low freezes scan, blanks outputs)
//   digits_in  NUM_DIGITS packed BCD digits, digit 0 in [3:0] (rightmost)
//   dp_in      decimal point per digit, active-high
//   load       one-cycle capture strobe into the shadow register
//   seg_out    {g,f,e,d,c,b,a}, active-high
//   dp_out     decimal point of the active digit
//   dig_en     one-hot digit enable, active-high
//   frame_done one-cycle pulse after each full scan frame
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    ena;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;

  modport master (
    output ena, digits_in, dp_in, load,
    input  seg_out, dp_out, dig_en, frame_done
  );

  modport slave (
    input  ena, digits_in, dp_in, load,
    output seg_out, dp_out, dig_en, frame_done
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes NUM_DIGITS BCD digits (+ decimal points)
// onto one registered 7-segment bus with one-hot digit enables.
// Incoming values are captured into a shadow register and only copied to
// the display register at a frame boundary, so a frame never tears. Each
// digit slot begins with BLANK_CYCLES cycles of all-enables-off to stop
// ghosting while the segment lines settle.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active-low
//   bus    seg7_scan_if.slave (ena, digits_in, dp_in, load in;
//          seg_out, dp_out, dig_en, frame_done out)
//
// Parameters: NUM_DIGITS (2..8), SCAN_DIV (cycles per slot, > BLANK_CYCLES),
// BLANK_CYCLES (blank cycles at slot start, 0 allowed).
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   Defined: digit i>=1 shows blank segments when it and every higher digit
//   are zero; dig_en/dp_out unaffected; digit 0 is never suppressed.
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;

  // With no blank interval the counter-0 slot position is already DRIVE.
  localparam state_e ST_RESET = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  digits_t               digits_pk;
  assign digits_pk = bus.digits_in;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  state_e                state_q, state_d;
  digits_t               shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  digits_t               disp_q, disp_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lz_blank;

  assign slot_end  = (cnt_q == CNT_LAST);
  // Frame boundary only exists while scanning; ena=0 holds everything.
  assign frame_end = bus.ena && slot_end && (idx_q == IDX_LAST);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic upper_zero;
  // Walk from the most significant digit down; a digit is suppressed while
  // it and everything above it are zero. Digit 0 is left out of the walk.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & (disp_q[i] == 4'd0);
      lz_blank[i] = upper_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Slot counter and digit index.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (bus.ena) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // BLANK/DRIVE follows the slot position the counter moves to, so state_q
  // always describes cnt_q.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BLANK: if (cnt_d >= CNT_BLANK) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_d <  CNT_BLANK) state_d = ST_BLANK;
      default:  state_d = ST_RESET;
    endcase
  end

  // Shadow capture and display update. A load coinciding with the boundary
  // goes straight to the display, leaving nothing pending.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pending_d   = pending_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    if (bus.load) begin
      shadow_d    = digits_pk;
      shadow_dp_d = bus.dp_in;
      pending_d   = 1'b1;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      if (bus.load) begin
        disp_d    = digits_pk;
        disp_dp_d = bus.dp_in;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
    end
  end

  // Registered outputs for the current slot position.
  always_comb begin
    seg_d        = '0;
    dp_d         = 1'b0;
    dig_en_d     = '0;
    frame_done_d = frame_end;
    if (bus.ena && (state_q == ST_DRIVE)) begin
      dig_en_d[idx_q] = 1'b1;
      seg_d           = lz_blank[idx_q] ? 7'h00 : seg_decode(disp_q[idx_q]);
      dp_d            = disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_RESET;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.dig_en     = dig_en_q;
  assign bus.frame_done = frame_done_q;

endmodule
